// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths/limits and the
// arbitration FSM state encoding.
package wb_arbiter_pkg;

  localparam int unsigned REG_WIDTH_DEF    = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    PIPE_PRI    = 1'b0,
    FORCE_DRAIN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Result buffer for the multi-cycle unit.
//   clk, reset  : clock, synchronous active-high reset (pointers/count cleared)
//   push        : write push_data at the tail on the rising edge
//   pop         : drop the head entry on the rising edge
//   pop_data    : current head entry
//   full, empty : derived from the registered count
//   count       : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the
// buffered multi-cycle unit results. The pipeline has priority; a starvation
// counter (or a full buffer) forces a one-cycle drain of the buffer head.
//   clk, reset                   : clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data       : pipeline writeback request
//   wb_stall                     : pipeline not granted this cycle
//   mdu_valid/mdu_rd/mdu_data    : multi-cycle result, accepted when mdu_ready
//   mdu_ready                    : buffer has room (registered count only)
//   mdu_pending                  : buffer non-empty
//   rf_we/rf_waddr/rf_wdata      : register-file write port (combinational)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = REG_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]  wb_data,
  output logic                  wb_stall,
  input  logic                  mdu_valid,
  input  logic [ADDR_WIDTH-1:0] mdu_rd,
  input  logic [REG_WIDTH-1:0]  mdu_data,
  output logic                  mdu_ready,
  output logic                  mdu_pending,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [REG_WIDTH-1:0]  rf_wdata
);

  localparam int unsigned EW = ADDR_WIDTH + REG_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT+1);

  arb_state_e            state, state_next;
  logic [SW-1:0]         starve, starve_next;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         head;
  logic                  grant_pipe, grant_fifo;
  logic                  push;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [REG_WIDTH-1:0]  head_data;

  // Ready/pending are forced low while reset is held, not just after it.
  assign mdu_ready   = !reset && !fifo_full;
  assign mdu_pending = !reset && !fifo_empty;
  assign push        = mdu_valid && mdu_ready;
  assign head_rd     = head[EW-1:REG_WIDTH];
  assign head_data   = head[REG_WIDTH-1:0];

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mdu_rd, mdu_data}),
    .pop       (grant_fifo),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= PIPE_PRI;
      starve <= '0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
    end
  end

  always_comb begin
    grant_pipe  = 1'b0;
    grant_fifo  = 1'b0;
    wb_stall    = 1'b0;
    state_next  = state;
    starve_next = starve;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;

    if (!reset) begin
      unique case (state)
        PIPE_PRI: begin
          if (wb_valid) begin
            grant_pipe = 1'b1;
          end else if (!fifo_empty) begin
            grant_fifo = 1'b1;
          end
        end
        FORCE_DRAIN: begin
          grant_fifo = !fifo_empty;
          wb_stall   = wb_valid;
        end
        default: ;
      endcase

      if (grant_fifo || fifo_empty) begin
        starve_next = '0;
      end else if (grant_pipe && starve != SW'(STARVE_LIMIT)) begin
        starve_next = starve + 1'b1;
      end

      if (state == PIPE_PRI) begin
        // A full buffer would otherwise block the producer until the
        // starvation limit; drain it as soon as the pipeline takes the port.
        if (starve_next == SW'(STARVE_LIMIT) ||
            (fifo_count == CW'(FIFO_DEPTH) && grant_pipe)) begin
          state_next = FORCE_DRAIN;
        end
      end else begin
        state_next  = PIPE_PRI;
        starve_next = '0;
      end

      if (grant_pipe) begin
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
        rf_we    = (wb_rd != '0);
      end else if (grant_fifo) begin
        rf_waddr = head_rd;
        rf_wdata = head_data;
        rf_we    = (head_rd != '0);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        mdu_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .REG_WIDTH    (32),
    .ADDR_WIDTH   (5),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_stall    (wb_stall),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .mdu_pending (mdu_pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well before the next rising edge.
  task automatic drive(input logic rst, input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] md);
    @(negedge clk);
    reset     = rst;
    wb_valid  = wv;
    wb_rd     = wrd;
    wb_data   = wd;
    mdu_valid = mv;
    mdu_rd    = mrd;
    mdu_data  = md;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input logic stall);
    chk({tag, ".we"},    rf_we,    we);
    chk({tag, ".addr"},  rf_waddr, addr);
    chk({tag, ".data"},  rf_wdata, data);
    chk({tag, ".stall"}, wb_stall, stall);
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

    // Held in reset with both requesters active: everything quiet.
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    expect_wr("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst.ready", mdu_ready, 1'b0);
    chk("rst.pend",  mdu_pending, 1'b0);

    // Single buffered result written the cycle after enqueue.
    idle();
    chk("idle.ready", mdu_ready, 1'b1);
    chk("idle.pend",  mdu_pending, 1'b0);
    expect_wr("idle", 1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5);
    chk("enq.we", rf_we, 1'b0);
    idle();
    expect_wr("mdu5", 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0);
    chk("mdu5.pend", mdu_pending, 1'b1);
    idle();
    chk("mdu5.after.pend", mdu_pending, 1'b0);
    chk("mdu5.after.we",   rf_we, 1'b0);

    // Starvation: enqueue alongside the pipeline, 4 more pipeline grants
    // with the entry waiting, then a forced drain, then the pipeline again.
    drive(1'b0, 1'b1, 5'd7, 32'h11110000, 1'b1, 5'd9, 32'hBEEF0009);
    expect_wr("st.c0", 1'b1, 5'd7, 32'h11110000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 5'd7, 32'h11110000 + 32'(i), 1'b0, 5'd0, 32'd0);
      expect_wr($sformatf("st.c%0d", i), 1'b1, 5'd7, 32'h11110000 + 32'(i), 1'b0);
      chk($sformatf("st.c%0d.pend", i), mdu_pending, 1'b1);
    end
    drive(1'b0, 1'b1, 5'd7, 32'h11110005, 1'b0, 5'd0, 32'd0);
    expect_wr("st.drain", 1'b1, 5'd9, 32'hBEEF0009, 1'b1);
    drive(1'b0, 1'b1, 5'd7, 32'h11110005, 1'b0, 5'd0, 32'd0);
    expect_wr("st.resume", 1'b1, 5'd7, 32'h11110005, 1'b0);
    chk("st.resume.pend", mdu_pending, 1'b0);
    idle();

    // Full buffer while the pipeline holds the port.
    drive(1'b0, 1'b1, 5'd2, 32'hD0, 1'b1, 5'd10, 32'hA0);
    chk("full.a.ready", mdu_ready, 1'b1);
    drive(1'b0, 1'b1, 5'd2, 32'hD1, 1'b1, 5'd11, 32'hB0);
    chk("full.b.ready", mdu_ready, 1'b1);
    expect_wr("full.b", 1'b1, 5'd2, 32'hD1, 1'b0);
    drive(1'b0, 1'b1, 5'd2, 32'hD2, 1'b0, 5'd0, 32'd0);
    chk("full.c.ready", mdu_ready, 1'b0);
    expect_wr("full.c", 1'b1, 5'd2, 32'hD2, 1'b0);
    drive(1'b0, 1'b1, 5'd2, 32'hD3, 1'b0, 5'd0, 32'd0);
    chk("full.d.ready", mdu_ready, 1'b0);
    expect_wr("full.d", 1'b1, 5'd10, 32'hA0, 1'b1);
    drive(1'b0, 1'b1, 5'd2, 32'hD3, 1'b0, 5'd0, 32'd0);
    chk("full.e.ready", mdu_ready, 1'b1);
    expect_wr("full.e", 1'b1, 5'd2, 32'hD3, 1'b0);
    idle();
    expect_wr("full.f", 1'b1, 5'd11, 32'hB0, 1'b0);
    idle();
    chk("full.g.pend", mdu_pending, 1'b0);

    // x0 destinations: slot used, no write, FIFO still pops.
    drive(1'b0, 1'b1, 5'd0, 32'h123, 1'b1, 5'd0, 32'h456);
    expect_wr("x0.pipe", 1'b0, 5'd0, 32'h123, 1'b0);
    idle();
    expect_wr("x0.mdu", 1'b0, 5'd0, 32'h456, 1'b0);
    chk("x0.mdu.pend", mdu_pending, 1'b1);
    idle();
    chk("x0.after.pend", mdu_pending, 1'b0);
    chk("x0.after.data", rf_wdata, 32'd0);

    // Simultaneous push/pop at count 1, order kept across pointer wrap.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd1);
    chk("ord.a.we", rf_we, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd2);
    expect_wr("ord.b", 1'b1, 5'd1, 32'd1, 1'b0);
    chk("ord.b.ready", mdu_ready, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd3);
    expect_wr("ord.c", 1'b1, 5'd2, 32'd2, 1'b0);
    chk("ord.c.ready", mdu_ready, 1'b1);
    idle();
    expect_wr("ord.d", 1'b1, 5'd3, 32'd3, 1'b0);
    idle();
    chk("ord.e.pend", mdu_pending, 1'b0);
    chk("ord.e.we",   rf_we, 1'b0);

    // Reset with two buffered entries discards them.
    drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33);
    drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
    drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    chk("rr.pre.ready", mdu_ready, 1'b0);
    chk("rr.pre.pend",  mdu_pending, 1'b1);
    drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    expect_wr("rr.in", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rr.in.ready", mdu_ready, 1'b0);
    chk("rr.in.pend",  mdu_pending, 1'b0);
    idle();
    expect_wr("rr.out", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rr.out.ready", mdu_ready, 1'b1);
    chk("rr.out.pend",  mdu_pending, 1'b0);
    idle();
    chk("rr.out2.we",   rf_we, 1'b0);
    chk("rr.out2.pend", mdu_pending, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
